// File: rtl/audio_pwm_out.sv
// Multi-channel 1-bit audio output stage: buffered signed samples, per-period attenuation,
// and PWM / alternating PWM / first-order sigma-delta / mute output per channel.
module audio_pwm_out #(
    parameter int CHANNELS   = 2,
    parameter int A_BITS     = 11,
    parameter int PWM_BITS   = 7,
    parameter int ATTEN_BITS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [CHANNELS*A_BITS-1:0]   sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic [1:0]                   mode,
    input  logic [ATTEN_BITS-1:0]        atten,
    output logic [CHANNELS-1:0]          audio_out,
    output logic                         period_start,
    output logic                         underrun
);

    localparam logic [1:0] MODE_PWM = 2'd0;
    localparam logic [1:0] MODE_ALT = 2'd1;
    localparam logic [1:0] MODE_SD  = 2'd2;
    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0]                cnt_q, cnt_d;
    logic                               phase_q, phase_d;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  acc_q, acc_d;
    logic [1:0]                         mode_r_q, mode_r_d;
    logic [ATTEN_BITS-1:0]              atten_r_q, atten_r_d;
    logic [CHANNELS*A_BITS-1:0]         active_q, active_d;
    logic [CHANNELS*A_BITS-1:0]         pending_q, pending_d;
    logic                               pending_full_q, pending_full_d;
    logic                               armed_q, armed_d;
    logic                               underrun_q, underrun_d;
    logic [CHANNELS-1:0]                audio_q, audio_d;
    logic                               period_start_q, period_start_d;

    logic                               boundary;
    logic                               xfer;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  level;
    logic [CHANNELS-1:0][PWM_BITS:0]    acc_sum;

    // Attenuate, then map the top bits of the signed sample to offset binary.
    function automatic logic [PWM_BITS-1:0] level_of(input logic signed [A_BITS-1:0] smp,
                                                     input logic [ATTEN_BITS-1:0]     sh);
        logic signed [A_BITS-1:0] scaled;
        logic [A_BITS-1:0]        offs;
        scaled = smp >>> sh;
        offs   = {~scaled[A_BITS-1], scaled[A_BITS-2:0]};
        return PWM_BITS'(offs >> (A_BITS - PWM_BITS));
    endfunction

    function automatic logic out_bit(input logic [1:0]          md,
                                     input logic                ph,
                                     input logic [PWM_BITS-1:0] lvl,
                                     input logic [PWM_BITS-1:0] cn,
                                     input logic                sd_bit);
        logic b;
        case (md)
            MODE_PWM: b = (lvl > cn);
            MODE_ALT: b = ph ? (lvl > ~cn) : (lvl > cn);
            MODE_SD:  b = sd_bit;
            default:  b = 1'b0;
        endcase
        return b;
    endfunction

    assign sample_ready = !pending_full_q && !reset;
    assign xfer         = sample_valid && sample_ready;
    assign boundary     = enable && (cnt_q == CNT_MAX);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            level[c]   = level_of(active_q[c*A_BITS +: A_BITS], atten_r_q);
            acc_sum[c] = {1'b0, acc_q[c]} + {1'b0, level[c]};
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        phase_d        = phase_q;
        acc_d          = acc_q;
        mode_r_d       = mode_r_q;
        atten_r_d      = atten_r_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        armed_d        = armed_q;
        underrun_d     = underrun_q;
        audio_d        = audio_q;
        period_start_d = boundary;

        if (enable) begin
            cnt_d = cnt_q + PWM_BITS'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                audio_d[c] = out_bit(mode_r_q, phase_q, level[c], cnt_q, acc_sum[c][PWM_BITS]);
                if (mode_r_q == MODE_SD) begin
                    acc_d[c] = acc_sum[c][PWM_BITS-1:0];
                end
            end
        end

        // Period boundary: swap in the pending samples and latch the new settings.
        if (boundary) begin
            if (pending_full_q) begin
                active_d       = pending_q;
                pending_full_d = 1'b0;
            end else if (armed_q) begin
                underrun_d = 1'b1;
            end
            mode_r_d  = mode;
            atten_r_d = atten;
            if (mode != mode_r_q) begin
                acc_d   = '0;
                phase_d = 1'b0;
            end else begin
                phase_d = ~phase_q;
            end
        end

        // Ready is low while full, so this never collides with the drain above.
        if (xfer) begin
            pending_d      = sample_in;
            pending_full_d = 1'b1;
            armed_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            phase_q        <= 1'b0;
            acc_q          <= '0;
            mode_r_q       <= '0;
            atten_r_q      <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            armed_q        <= 1'b0;
            underrun_q     <= 1'b0;
            audio_q        <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
            acc_q          <= acc_d;
            mode_r_q       <= mode_r_d;
            atten_r_q      <= atten_r_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            armed_q        <= armed_d;
            underrun_q     <= underrun_d;
            audio_q        <= audio_d;
            period_start_q <= period_start_d;
        end
    end

    assign audio_out    = audio_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: per-period high-cycle expectations are queued by the stimulus
// and checked by a monitor that closes each period on period_start.
module tb_audio_pwm_out;
    localparam int CH  = 2;
    localparam int AB  = 11;
    localparam int PB  = 7;
    localparam int ATB = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [CH*AB-1:0]  sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [1:0]        mode;
    logic [ATB-1:0]    atten;
    logic [CH-1:0]     audio_out;
    logic              period_start;
    logic              underrun;

    audio_pwm_out #(.CHANNELS(CH), .A_BITS(AB), .PWM_BITS(PB), .ATTEN_BITS(ATB)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .mode(mode),
        .atten(atten),
        .audio_out(audio_out),
        .period_start(period_start),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi0;
        int hi1;
        int first0;
        int runs0;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int h0, input int h1, input int f0, input int r0);
        exp_t e;
        e.hi0 = h0; e.hi1 = h1; e.first0 = f0; e.runs0 = r0;
        sbq.push_back(e);
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 400);
        if (!period_start) begin
            checks++;
            failures++;
            $display("FAIL wait_period_start: got timeout after %0d cycles expected a pulse", n);
        end
    endtask

    task automatic send(input int s0, input int s1);
        int k = 0;
        while (!sample_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!sample_ready) begin
            checks++;
            failures++;
            $display("FAIL send_ready: got ready=0 for %0d cycles expected 1", k);
        end
        sample_in    = {AB'(s1), AB'(s0)};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Monitor: accumulate fresh output samples, close the window on period_start.
    initial begin
        logic en_s, rst_s, prev0;
        int   hi0, hi1, first0, runs0, idx;
        exp_t e;
        hi0 = 0; hi1 = 0; first0 = -1; runs0 = 0; idx = 0; prev0 = 1'b0;
        forever begin
            @(posedge clk);
            en_s  = enable;
            rst_s = reset;
            #1;
            if (rst_s) begin
                hi0 = 0; hi1 = 0; first0 = -1; runs0 = 0; idx = 0; prev0 = 1'b0;
            end else begin
                if (en_s) begin
                    if (audio_out[0]) begin
                        hi0++;
                        if (first0 < 0) first0 = idx;
                        if (!prev0) runs0++;
                    end
                    prev0 = audio_out[0];
                    if (audio_out[1]) hi1++;
                    idx++;
                end
                if (period_start) begin
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("period_total", idx, 1 << PB);
                        chk("ch0_high", hi0, e.hi0);
                        chk("ch1_high", hi1, e.hi1);
                        if (e.first0 >= 0) chk("ch0_first_high", first0, e.first0);
                        if (e.runs0 >= 0) chk("ch0_runs", runs0, e.runs0);
                    end
                    hi0 = 0; hi1 = 0; first0 = -1; runs0 = 0; idx = 0; prev0 = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int nchg;
        logic [CH-1:0] ao;
        reset = 1'b1; enable = 1'b1; sample_in = '0; sample_valid = 1'b0;
        mode = 2'd0; atten = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(sample_ready), 0);
        chk("rst_audio", int'(audio_out), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_underrun", int'(underrun), 0);
        reset = 1'b0;
        push(64, 64, 0, 1);
        @(negedge clk);
        chk("ready_after_reset", int'(sample_ready), 1);

        wait_ps(n); push(64, 64, 0, 1);
        wait_ps(n);
        chk("period_len", n, 128);
        chk("no_underrun_unarmed", int'(underrun), 0);
        push(64, 64, 0, 1);

        send(1023, -1024);
        chk("ready_while_full", int'(sample_ready), 0);
        wait_ps(n);
        chk("ready_drained", int'(sample_ready), 1);
        push(127, 0, 0, 1);

        send(-512, 0); mode = 2'd1;
        wait_ps(n); push(32, 64, 0, 1);
        send(-512, 0);
        wait_ps(n); push(32, 64, 96, 1);

        send(-1008, 0); mode = 2'd2;
        wait_ps(n); push(1, 64, 127, 1);
        send(0, -1008);
        wait_ps(n); push(64, 1, 1, 64);
        send(0, 0); mode = 2'd0;
        wait_ps(n); push(64, 64, 0, 1);
        send(-1008, 0); mode = 2'd2;
        wait_ps(n); push(1, 64, 127, 1);

        send(1023, 1023); mode = 2'd0; atten = 2'd2;
        wait_ps(n); push(79, 79, 0, 1);
        chk("no_underrun_fed", int'(underrun), 0);
        repeat (30) @(negedge clk);
        enable = 1'b0;
        ao = audio_out;
        nchg = 0;
        repeat (10) begin
            @(negedge clk);
            if (audio_out !== ao) nchg++;
        end
        enable = 1'b1;
        chk("freeze_changes", nchg, 0);
        chk("freeze_value", int'(ao), 3);
        wait_ps(n);
        chk("stretched_len", 40 + n, 138);
        chk("underrun_set", int'(underrun), 1);

        atten = '0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_audio", int'(audio_out), 0);
        chk("rst2_underrun", int'(underrun), 0);
        chk("rst2_period_start", int'(period_start), 0);
        chk("rst2_ready", int'(sample_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        push(64, 64, 0, 1);
        @(negedge clk);
        chk("rst2_ready_after", int'(sample_ready), 1);
        send(1023, -1024);
        wait_ps(n); push(127, 0, 0, 1);
        chk("loaded_ready", int'(sample_ready), 1);
        chk("loaded_no_underrun", int'(underrun), 0);
        repeat (100) @(negedge clk);
        chk("underrun_before", int'(underrun), 0);
        wait_ps(n); push(127, 0, 0, 1);
        chk("underrun_after", int'(underrun), 1);
        wait_ps(n);
        chk("underrun_sticky", int'(underrun), 1);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
